// File: rtl/usrt_pkg.sv
// Shared types and constants for the USRT transmit scheduler.
package usrt_pkg;

  localparam int CFG_W           = 5;
  localparam int PARITY_MSB      = 4;
  localparam int PARITY_LSB      = 3;
  localparam int BAUD_MSB        = 2;
  localparam int BAUD_LSB        = 0;
  localparam int DEFAULT_TIMEOUT = 16383;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG     = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Field order matches the control-register layout: parity on top, baud below.
  typedef struct packed {
    logic [PARITY_MSB-PARITY_LSB:0] parity;
    logic [BAUD_MSB-BAUD_LSB:0]     baud;
  } cfg_t;

  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usrt_tx_sched_if.sv
// Request/winner bundle between the scheduler FSM and its round-robin arbiter.
interface usrt_tx_sched_if;
  logic [1:0] req;
  logic       upd;
  logic       upd_idx;
  logic [1:0] winner;
  logic       valid;

  modport master (output req, upd, upd_idx, input winner, valid);
  modport slave  (input req, upd, upd_idx, output winner, valid);
endinterface

// File: rtl/usrt_rr_arb.sv
// Two-way round-robin selector; on a tie the requester not granted last wins.
module usrt_rr_arb (
  input logic             clk,
  input logic             rst_n,
  usrt_tx_sched_if.slave  arb
);

  logic r_last;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    arb.winner = 2'b00;
    unique case (arb.req)
      2'b01:   arb.winner = 2'b01;
      2'b10:   arb.winner = 2'b10;
      2'b11:   arb.winner = r_last ? 2'b01 : 2'b10;
      default: arb.winner = 2'b00;
    endcase
  end

  assign arb.valid = |arb.req;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= 1'b1;
    else if (arb.upd) r_last <= arb.upd_idx;
  end

endmodule

// File: rtl/usrt_tx_sched.sv
// Two-requester transmit scheduler: arbitrate, reprogram control reg on cfg change, run tx.
// Optional watchdog on wait states: define USRT_SCHED_TIMEOUT_EN.
module usrt_tx_sched
  import usrt_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             i_Pclk,
  input  logic             i_Reset_n,
  input  logic [1:0]       i_Req,
  input  logic [CFG_W-1:0] i_Cfg0,
  input  logic [CFG_W-1:0] i_Cfg1,
  input  logic [7:0]       i_Data0,
  input  logic [7:0]       i_Data1,
  output logic [1:0]       o_Grant,
  output logic [1:0]       o_Done,
  output logic             o_Ctrl_En,
  output logic             o_Ctrl_Write,
  output logic [7:0]       o_Ctrl_Data,
  input  logic             i_Ctrl_Ready,
  output logic             o_Tx_Start,
  output logic [7:0]       o_Tx_Data,
  input  logic             i_Tx_Busy,
  output logic             o_Active,
  output logic             o_Owner,
  output logic             o_Timeout
);

  state_t     r_state;
  logic       r_owner;
  cfg_t       r_cfg;
  cfg_t       r_shadow;
  logic       r_shadow_vld;
  logic [7:0] r_data;
  logic [1:0] r_grant;

  logic       w_win_idx;
  cfg_t       w_sel_cfg;
  logic       w_tmo;
  logic       w_upd;

  usrt_tx_sched_if w_arb ();

  assign w_arb.req     = i_Req;
  assign w_arb.upd     = w_upd;
  assign w_arb.upd_idx = r_owner;

  usrt_rr_arb u_arb (
    .clk   (i_Pclk),
    .rst_n (i_Reset_n),
    .arb   (w_arb)
  );

  assign w_win_idx = w_arb.winner[1];
  assign w_sel_cfg = w_win_idx ? cfg_t'(i_Cfg1) : cfg_t'(i_Cfg0);
  assign w_upd     = (r_state == S_DONE) || w_tmo;

`ifdef USRT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_wait;
  logic             w_leave;
  logic             w_cnt_en;

  assign w_wait  = (r_state == S_CFG) || (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign w_leave = ((r_state == S_CFG)     &&  i_Ctrl_Ready) ||
                   ((r_state == S_WAIT_HI) &&  i_Tx_Busy)    ||
                   ((r_state == S_WAIT_LO) && !i_Tx_Busy);
  // Counting only while staying put also clears the count on every state change.
  assign w_cnt_en = w_wait && !w_leave;
  assign w_tmo    = w_cnt_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (w_cnt_en && !w_tmo) ? r_cnt + 1'b1 : '0;
      r_timeout <= w_tmo;
    end
  end

  assign o_Timeout = r_timeout;
`else
  assign w_tmo     = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // reads the values from before this edge and the later timeout override wins.
  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_cfg        <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_data       <= '0;
      r_grant      <= 2'b00;
    end else begin
      r_grant <= 2'b00;
      unique case (r_state)
        S_IDLE: begin
          if (w_arb.valid) begin
            r_owner <= w_win_idx;
            r_grant <= w_arb.winner;
            r_cfg   <= w_sel_cfg;
            r_data  <= w_win_idx ? i_Data1 : i_Data0;
            r_state <= (!r_shadow_vld || (w_sel_cfg != r_shadow)) ? S_CFG : S_START;
          end
        end
        S_CFG: begin
          if (i_Ctrl_Ready) begin
            r_shadow     <= r_cfg;
            r_shadow_vld <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START:   r_state <= S_WAIT_HI;
        S_WAIT_HI: if (i_Tx_Busy)  r_state <= S_WAIT_LO;
        S_WAIT_LO: if (!i_Tx_Busy) r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
      if (w_tmo) begin
        r_state      <= S_IDLE;
        r_shadow_vld <= 1'b0;
      end
    end
  end

  assign o_Grant      = r_grant;
  assign o_Done       = (r_state == S_DONE) ? idx2oh(r_owner) : 2'b00;
  assign o_Ctrl_En    = (r_state == S_CFG);
  assign o_Ctrl_Write = (r_state == S_CFG);
  assign o_Ctrl_Data  = {3'b000, r_cfg};
  assign o_Tx_Start   = (r_state == S_START);
  assign o_Tx_Data    = r_data;
  assign o_Active     = (r_state != S_IDLE);
  assign o_Owner      = r_owner;

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Self-checking bench for usrt_tx_sched: directed scenarios then randomized rounds
// against a transaction-level model. Watchdog scenario runs when USRT_SCHED_TIMEOUT_EN is defined.
module tb_usrt_tx_sched;

`ifdef USRT_SCHED_TIMEOUT_EN
  localparam int TO    = 8;
  localparam int MAX_L = 6;
  localparam int DIR_L = 6;
`else
  localparam int TO    = 16383;
  localparam int MAX_L = 10;
  localparam int DIR_L = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_Req;
  logic [4:0] i_Cfg0, i_Cfg1;
  logic [7:0] i_Data0, i_Data1;
  logic [1:0] o_Grant, o_Done;
  logic       o_Ctrl_En, o_Ctrl_Write;
  logic [7:0] o_Ctrl_Data;
  logic       i_Ctrl_Ready;
  logic       o_Tx_Start;
  logic [7:0] o_Tx_Data;
  logic       i_Tx_Busy;
  logic       o_Active, o_Owner, o_Timeout;

  usrt_tx_sched #(.TIMEOUT(TO)) dut (
    .i_Pclk       (clk),
    .i_Reset_n    (rst_n),
    .i_Req        (i_Req),
    .i_Cfg0       (i_Cfg0),
    .i_Cfg1       (i_Cfg1),
    .i_Data0      (i_Data0),
    .i_Data1      (i_Data1),
    .o_Grant      (o_Grant),
    .o_Done       (o_Done),
    .o_Ctrl_En    (o_Ctrl_En),
    .o_Ctrl_Write (o_Ctrl_Write),
    .o_Ctrl_Data  (o_Ctrl_Data),
    .i_Ctrl_Ready (i_Ctrl_Ready),
    .o_Tx_Start   (o_Tx_Start),
    .o_Tx_Data    (o_Tx_Data),
    .i_Tx_Busy    (i_Tx_Busy),
    .o_Active     (o_Active),
    .o_Owner      (o_Owner),
    .o_Timeout    (o_Timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: pending requests, last winner, programmed shadow.
  bit         pend   [2];
  logic [4:0] cfg_m  [2];
  logic [7:0] dat_m  [2];
  bit         last_m;
  bit         sh_vld_m;
  logic [4:0] sh_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    i_Req   = {pend[1], pend[0]};
    i_Cfg0  = cfg_m[0];
    i_Cfg1  = cfg_m[1];
    i_Data0 = dat_m[0];
    i_Data1 = dat_m[1];
  endtask

  function automatic logic [4:0] pick_cfg();
    case ($urandom_range(0, 2))
      0:       return 5'b00011;
      1:       return 5'b11010;
      default: return 5'b01101;
    endcase
  endfunction

  function automatic logic [25:0] all_outs();
    return {o_Grant, o_Done, o_Ctrl_En, o_Ctrl_Write, o_Ctrl_Data,
            o_Tx_Start, o_Tx_Data, o_Active, o_Owner, o_Timeout};
  endfunction

  // Entered at the falling edge of an idle cycle with requests driven; returns at the
  // falling edge of the next idle cycle. d = extra ready delay, g = start-to-busy gap,
  // l = busy length, keep = requester keeps its request high, tmo = busy never rises.
  task automatic round(input int d, input int g, input int l, input bit keep, input bit tmo);
    int w;
    bit rc;
    w  = (pend[0] && pend[1]) ? (last_m ? 0 : 1) : (pend[0] ? 0 : 1);
    rc = !sh_vld_m || (cfg_m[w] != sh_m);
    check("idle_inactive", o_Active, 0);
    @(negedge clk);
    check("grant", o_Grant, 32'(1 << w));
    check("owner", o_Owner, w);
    if (!keep) pend[w] = 1'b0;
    drive();
    if (rc) begin
      check("strobe", {o_Ctrl_En, o_Ctrl_Write}, 2'b11);
      check("ctrl_data", o_Ctrl_Data, {3'b000, cfg_m[w]});
      check("no_start_in_cfg", o_Tx_Start, 0);
      repeat (1 + d) begin
        @(negedge clk);
        check("strobe_hold", o_Ctrl_En, 1);
      end
      i_Ctrl_Ready = 1'b1;
      @(negedge clk);
      i_Ctrl_Ready = 1'b0;
      check("strobe_drop", o_Ctrl_En, 0);
      sh_m     = cfg_m[w];
      sh_vld_m = 1'b1;
    end else begin
      check("no_strobe", o_Ctrl_En, 0);
    end
    check("tx_start", o_Tx_Start, 1);
    check("tx_data", o_Tx_Data, dat_m[w]);
    if (tmo) begin
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk);
        if (j == 8) check("timeout_early", o_Timeout, 0);
      end
      @(negedge clk);
      check("timeout_pulse", o_Timeout, 1);
      check("timeout_no_done", o_Done, 0);
      last_m   = w[0];
      sh_vld_m = 1'b0;
    end else begin
      repeat (g) begin
        @(negedge clk);
        check("start_one_cycle", o_Tx_Start, 0);
      end
      i_Tx_Busy = 1'b1;
      repeat (l) begin
        @(negedge clk);
        check("no_early_done", o_Done, 0);
      end
      i_Tx_Busy = 1'b0;
      @(negedge clk);
      check("done", o_Done, 32'(1 << w));
      check("tx_data_hold", o_Tx_Data, dat_m[w]);
      last_m = w[0];
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    i_Ctrl_Ready = 1'b0;
    i_Tx_Busy    = 1'b0;
    pend[0] = 0; pend[1] = 0;
    cfg_m[0] = '0; cfg_m[1] = '0;
    dat_m[0] = '0; dat_m[1] = '0;
    last_m = 1'b1; sh_vld_m = 1'b0; sh_m = '0;
    drive();
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First transfer always programs the control register.
    pend[0] = 1; cfg_m[0] = 5'b00011; dat_m[0] = 8'hA5; drive();
    round(0, 0, DIR_L, 1'b0, 1'b0);
    // Same cfg: straight to start.
    pend[0] = 1; dat_m[0] = 8'h5A; drive();
    round(0, 1, 3, 1'b0, 1'b0);

    // Reset while waiting for busy to fall.
    pend[0] = 1; dat_m[0] = 8'hC3; drive();
    @(negedge clk);
    check("rst_grant", o_Grant, 2'b01);
    pend[0] = 0; drive();
    check("rst_start", o_Tx_Start, 1);
    i_Tx_Busy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_active", o_Active, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outputs", all_outs(), 0);
    i_Tx_Busy = 1'b0;
    @(negedge clk);
    check("rst_no_done", o_Done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", o_Active, 0);
    check("rst_no_done2", o_Done, 0);
    last_m = 1'b1; sh_vld_m = 1'b0;
    // Same cfg as before, but the shadow was lost.
    pend[0] = 1; dat_m[0] = 8'h3C; drive();
    round(0, 0, 4, 1'b0, 1'b0);

    // Both requesting continuously with different cfgs: alternate and reprogram each time.
    pend[0] = 1; pend[1] = 1; cfg_m[0] = 5'b00011; cfg_m[1] = 5'b11010;
    dat_m[0] = 8'h11; dat_m[1] = 8'h22; drive();
    repeat (4) round(0, 0, 2, 1'b1, 1'b0);
    pend[0] = 0; pend[1] = 0; drive();
    @(negedge clk);
    check("quiet_no_grant", o_Grant, 0);
    check("quiet_idle", o_Active, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i]  = 1;
          cfg_m[i] = pick_cfg();
          dat_m[i] = 8'($urandom);
        end
      end
      drive();
      if (!pend[0] && !pend[1]) begin
        @(negedge clk);
        check("rand_no_grant", o_Grant, 0);
      end else begin
        round($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(2, MAX_L),
              $urandom_range(0, 3) == 0, 1'b0);
      end
    end

`ifdef USRT_SCHED_TIMEOUT_EN
    pend[0] = 1; pend[1] = 1; drive();
    round(0, 0, 2, 1'b0, 1'b1);
    round(0, 0, 2, 1'b0, 1'b0);
`endif

    pend[0] = 0; pend[1] = 0; drive();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
